// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS ALU-control path.
// Holds opcode/funct codes, aluop codes, the sequencer state encoding
// and the step numbers of the 10-step instruction cycle.
package mips_pkg;

    // Step numbers within one instruction cycle (cont = 0..CONT_MAX)
    localparam int unsigned CONT_EXEC    = 6;  // ula evaluates on this step
    localparam int unsigned CONT_AMOSTRA = 7;  // result captured leaving this step
    localparam int unsigned CONT_MAX     = 9;  // last step of the cycle

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    // ALU operation codes understood by ula
    localparam logic [3:0] ALUOP_AND      = 4'd0;
    localparam logic [3:0] ALUOP_OR       = 4'd1;
    localparam logic [3:0] ALUOP_ADD      = 4'd2;
    localparam logic [3:0] ALUOP_SUB      = 4'd6;
    localparam logic [3:0] ALUOP_SLT      = 4'd7;
    localparam logic [3:0] ALUOP_INVALIDA = 4'd15;

    typedef enum logic [0:0] {
        OCIOSO,
        EXECUTANDO
    } estado_t;

endpackage

// File: rtl/decodificador_aluop.sv
// Combinational instruction decoder for the ALU-control path.
// Ports:
//   instrucao    in  32 : MIPS instruction word
//   aluop        out 4  : ALU operation (15 when unsupported)
//   usa_imediato out 1  : second operand is the sign-extended imm[15:0]
//   eh_beq       out 1  : instruction is beq
//   erro         out 1  : opcode/funct not supported
module decodificador_aluop
    import mips_pkg::*;
(
    input  logic [31:0] instrucao,
    output logic [3:0]  aluop,
    output logic        usa_imediato,
    output logic        eh_beq,
    output logic        erro
);

    logic [5:0] opcode;
    logic [5:0] funct;

    assign opcode = instrucao[31:26];
    assign funct  = instrucao[5:0];

    always_comb begin
        aluop        = ALUOP_INVALIDA;
        usa_imediato = 1'b0;
        eh_beq       = 1'b0;
        erro         = 1'b1;
        unique case (opcode)
            OP_RTYPE: begin
                erro = 1'b0;
                unique case (funct)
                    FUNCT_ADD: aluop = ALUOP_ADD;
                    FUNCT_SUB: aluop = ALUOP_SUB;
                    FUNCT_AND: aluop = ALUOP_AND;
                    FUNCT_OR:  aluop = ALUOP_OR;
                    FUNCT_SLT: aluop = ALUOP_SLT;
                    default:   erro  = 1'b1;
                endcase
            end
            OP_LW, OP_SW, OP_ADDI: begin
                aluop        = ALUOP_ADD;
                usa_imediato = 1'b1;
                erro         = 1'b0;
            end
            OP_BEQ: begin
                aluop  = ALUOP_SUB;
                eh_beq = 1'b1;
                erro   = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sequenciador_ula.sv
// Multicycle sequencer driving the ula block.
// Accepts one instruction while idle, walks cont 1..9, presents operands to
// ula on step CONT_EXEC, captures resultado/zero leaving step CONT_AMOSTRA and
// pulses concluido as cont wraps back to 0.
// Ports:
//   clk, reset            : clock and synchronous active-high reset
//   instr_valida          : instrucao/rs_val/rt_val valid this cycle
//   instrucao, rs_val, rt_val : instruction and register operands
//   ocupado               : sequence in progress, new instructions ignored
//   cont, aluop, dado1, dado2 : to ula
//   zero, resultado       : from ula
//   resultado_q, desvio   : captured result and beq-taken decision
//   erro                  : last accepted instruction was unsupported
//   concluido             : one-cycle pulse, result fields valid
module sequenciador_ula
    import mips_pkg::*;
#(
    parameter int unsigned LARGURA   = 32,
    parameter int unsigned CONT_EXEC = mips_pkg::CONT_EXEC,
    parameter int unsigned CONT_MAX  = mips_pkg::CONT_MAX
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               instr_valida,
    input  logic [31:0]        instrucao,
    input  logic [LARGURA-1:0] rs_val,
    input  logic [LARGURA-1:0] rt_val,
    output logic               ocupado,
    output logic [3:0]         cont,
    output logic [3:0]         aluop,
    output logic [LARGURA-1:0] dado1,
    output logic [LARGURA-1:0] dado2,
    input  logic               zero,
    input  logic [LARGURA-1:0] resultado,
    output logic [LARGURA-1:0] resultado_q,
    output logic               desvio,
    output logic               erro,
    output logic               concluido
);

    localparam logic [3:0] PASSO_CARGA   = 4'(CONT_EXEC - 1);
    localparam logic [3:0] PASSO_AMOSTRA = 4'(CONT_AMOSTRA);
    localparam logic [3:0] PASSO_MAX     = 4'(CONT_MAX);

    estado_t    estado, estado_prox;
    logic [3:0] cont_prox;
    logic       aceita, carrega, captura, fim;

    // Decoder outputs for the incoming instruction
    logic [3:0] dec_aluop;
    logic       dec_usa_imediato, dec_eh_beq, dec_erro;

    // Operands latched at acceptance, presented to ula only at step CONT_EXEC
    logic [LARGURA-1:0] op1_q, op2_q;
    logic [LARGURA-1:0] imediato_ext;
    logic               eh_beq_q;

    decodificador_aluop u_decodificador (
        .instrucao    (instrucao),
        .aluop        (dec_aluop),
        .usa_imediato (dec_usa_imediato),
        .eh_beq       (dec_eh_beq),
        .erro         (dec_erro)
    );

    assign imediato_ext = {{(LARGURA-16){instrucao[15]}}, instrucao[15:0]};
    assign ocupado      = (estado == EXECUTANDO);

    always_comb begin
        estado_prox = estado;
        cont_prox   = cont;
        aceita      = 1'b0;
        carrega     = 1'b0;
        captura     = 1'b0;
        fim         = 1'b0;
        unique case (estado)
            OCIOSO: begin
                cont_prox = 4'd0;
                if (instr_valida) begin
                    aceita      = 1'b1;
                    estado_prox = EXECUTANDO;
                    cont_prox   = 4'd1;
                end
            end
            EXECUTANDO: begin
                if (cont >= PASSO_MAX) begin
                    fim         = 1'b1;
                    estado_prox = OCIOSO;
                    cont_prox   = 4'd0;
                end else begin
                    cont_prox = cont + 4'd1;
                end
                carrega = (cont == PASSO_CARGA);
                captura = (cont == PASSO_AMOSTRA);
            end
            default: begin
                estado_prox = OCIOSO;
                cont_prox   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado      <= OCIOSO;
            cont        <= 4'd0;
            concluido   <= 1'b0;
            aluop       <= 4'd0;
            erro        <= 1'b0;
            eh_beq_q    <= 1'b0;
            op1_q       <= '0;
            op2_q       <= '0;
            dado1       <= '0;
            dado2       <= '0;
            resultado_q <= '0;
            desvio      <= 1'b0;
        end else begin
            estado    <= estado_prox;
            cont      <= cont_prox;
            concluido <= fim;
            if (aceita) begin
                aluop    <= dec_aluop;
                erro     <= dec_erro;
                eh_beq_q <= dec_eh_beq;
                op1_q    <= rs_val;
                op2_q    <= dec_usa_imediato ? imediato_ext : rt_val;
            end
            if (carrega) begin
                dado1 <= op1_q;
                dado2 <= op2_q;
            end
            if (captura) begin
                resultado_q <= resultado;
                desvio      <= zero & eh_beq_q & ~erro;
            end
        end
    end

endmodule

// File: tb/tb_sequenciador_ula.sv
// Scoreboard bench for sequenciador_ula with a behavioural ula model.
module tb_sequenciador_ula;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valida;
    logic [31:0] instrucao;
    logic [31:0] rs_val, rt_val;
    logic        ocupado;
    logic [3:0]  cont, aluop;
    logic [31:0] dado1, dado2;
    logic        zero;
    logic [31:0] resultado;
    logic [31:0] resultado_q;
    logic        desvio, erro, concluido;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] res;
        logic        desvio;
        logic        erro;
        logic [3:0]  aluop;
        int          e0;
        string       nome;
    } esperado_t;

    esperado_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sequenciador_ula dut (
        .clk          (clk),
        .reset        (reset),
        .instr_valida (instr_valida),
        .instrucao    (instrucao),
        .rs_val       (rs_val),
        .rt_val       (rt_val),
        .ocupado      (ocupado),
        .cont         (cont),
        .aluop        (aluop),
        .dado1        (dado1),
        .dado2        (dado2),
        .zero         (zero),
        .resultado    (resultado),
        .resultado_q  (resultado_q),
        .desvio       (desvio),
        .erro         (erro),
        .concluido    (concluido)
    );

    // Behavioural ula
    always_comb begin
        case (aluop)
            4'd0:    resultado = dado1 & dado2;
            4'd1:    resultado = dado1 | dado2;
            4'd2:    resultado = dado1 + dado2;
            4'd6:    resultado = dado1 - dado2;
            4'd7:    resultado = ($signed(dado1) < $signed(dado2)) ? 32'd1 : 32'd0;
            default: resultado = 32'd0;
        endcase
        zero = (resultado == 32'd0);
    end

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] req);
        n_cmp++;
        if (atual !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nome, atual, req, $time);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".cont"}, 32'(cont), 32'd0);
        check({tag, ".aluop"}, 32'(aluop), 32'd0);
        check({tag, ".dado1"}, dado1, 32'd0);
        check({tag, ".dado2"}, dado2, 32'd0);
        check({tag, ".resultado_q"}, resultado_q, 32'd0);
        check({tag, ".desvio"}, 32'(desvio), 32'd0);
        check({tag, ".erro"}, 32'(erro), 32'd0);
        check({tag, ".concluido"}, 32'(concluido), 32'd0);
        check({tag, ".ocupado"}, 32'(ocupado), 32'd0);
    endtask

    // Monitor: every concluido pulse must match the oldest expected entry
    always @(negedge clk) begin
        if (concluido === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_concluido: got pulse, expected none (t=%0t)", $time);
            end else begin
                esperado_t e;
                e = sb.pop_front();
                check({e.nome, ".resultado_q"}, resultado_q, e.res);
                check({e.nome, ".desvio"}, 32'(desvio), 32'(e.desvio));
                check({e.nome, ".erro"}, 32'(erro), 32'(e.erro));
                check({e.nome, ".aluop"}, 32'(aluop), 32'(e.aluop));
                check({e.nome, ".latencia"}, 32'(cyc - e.e0), 32'd9);
                check({e.nome, ".cont_fim"}, 32'(cont), 32'd0);
            end
        end
    end

    // Issues one instruction at the next falling edge and follows it through
    // steps 1..9; returns at the falling edge where cont == 9, so the next
    // call lands in the concluido cycle.
    task automatic run_instr(input string nome, input logic [31:0] instr,
                             input logic [31:0] rs, input logic [31:0] rt,
                             input logic [31:0] exp_res, input logic exp_desvio,
                             input logic exp_erro, input logic [3:0] exp_aluop,
                             input logic [31:0] exp_dado2, input bit injeta);
        esperado_t e;
        @(negedge clk);
        instr_valida = 1'b1;
        instrucao    = instr;
        rs_val       = rs;
        rt_val       = rt;
        e.res    = exp_res;
        e.desvio = exp_desvio;
        e.erro   = exp_erro;
        e.aluop  = exp_aluop;
        e.e0     = cyc + 1;
        e.nome   = nome;
        sb.push_back(e);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            instr_valida = 1'b0;
            check({nome, ".cont"}, 32'(cont), 32'(k));
            if (k == 1) begin
                check({nome, ".aluop_e0"}, 32'(aluop), 32'(exp_aluop));
                check({nome, ".ocupado"}, 32'(ocupado), 32'd1);
                check({nome, ".erro_e0"}, 32'(erro), 32'(exp_erro));
            end
            if (k == 3 && injeta) begin
                instr_valida = 1'b1;
                instrucao    = 32'h0022_1820;  // add
                rs_val       = 32'd1000;
                rt_val       = 32'd1;
            end
            if (k == 6) begin
                check({nome, ".dado1"}, dado1, rs);
                check({nome, ".dado2"}, dado2, exp_dado2);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        instr_valida = 1'b0;
        instrucao    = '0;
        rs_val       = '0;
        rt_val       = '0;
        repeat (2) @(negedge clk);
        check_reset("reset");
        reset = 1'b0;

        //        name    instr          rs            rt            res           dsv  err  op     dado2         inj
        run_instr("add",  32'h0022_1820, 32'd5,        32'd7,        32'd12,       0,   0,   4'd2,  32'd7,        0);
        run_instr("beq1", 32'h1022_0010, 32'd9,        32'd9,        32'd0,        1,   0,   4'd6,  32'd9,        0);
        run_instr("beq0", 32'h1022_0010, 32'd9,        32'd8,        32'd1,        0,   0,   4'd6,  32'd8,        0);
        run_instr("lw",   32'h8C22_FFFC, 32'd100,      32'd55,       32'd96,       0,   0,   4'd2,  32'hFFFF_FFFC, 0);
        run_instr("f03",  32'h0022_1803, 32'd3,        32'd4,        32'd0,        0,   1,   4'd15, 32'd4,        0);
        run_instr("sub",  32'h0022_1822, 32'd10,       32'd3,        32'd7,        0,   0,   4'd6,  32'd3,        1);
        run_instr("slt",  32'h0022_182A, 32'hFFFF_FFFF, 32'd2,       32'd1,        0,   0,   4'd7,  32'd2,        0);
        run_instr("or",   32'h0022_1825, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 0, 0, 4'd1,  32'h0000_000F, 0);
        run_instr("and",  32'h0022_1824, 32'h0000_0FF0, 32'h0000_03C3, 32'h0000_03C0, 0, 0, 4'd0,  32'h0000_03C3, 0);
        run_instr("addi", 32'h2022_FFFF, 32'd10,       32'd77,       32'd9,        0,   0,   4'd2,  32'hFFFF_FFFF, 0);
        run_instr("sw",   32'hAC22_0004, 32'd8,        32'd5,        32'd12,       0,   0,   4'd2,  32'd4,        0);
        run_instr("op3f", 32'hFC22_0000, 32'd6,        32'd6,        32'd0,        0,   1,   4'd15, 32'd6,        0);

        // Reset mid-sequence, with instr_valida high on the reset edge
        @(negedge clk);
        instr_valida = 1'b1;
        instrucao    = 32'hFC22_0000;
        rs_val       = 32'd1;
        rt_val       = 32'd2;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            instr_valida = 1'b0;
        end
        check("rst.cont_antes", 32'(cont), 32'd4);
        reset        = 1'b1;
        instr_valida = 1'b1;
        @(negedge clk);
        check_reset("rst_meio");
        reset        = 1'b0;
        instr_valida = 1'b0;
        repeat (12) @(negedge clk);
        check("fila_vazia", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
